tiny_dnn_ctrl: RTL and testbench

Sequencer for a chain of `tiny_dnn_core` MAC cores computing one fully connected layer pass. For each start it:
- clears the accumulators;
- streams the weight/input read addresses;
- optionally adds the bias term;
- waits out the core pipeline;
- drains the per-core results through the `sum`/`sum_in` shift chain under a valid/ready handshake.

Weight loading (`write`/`bwrite`/`wa`/`wd`) is outside this block.

---
 rtl/tiny_dnn_ctrl.sv | 120 ++++++++++++
 tb/tb_tiny_dnn_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_ctrl.sv
// rtl/tiny_dnn_ctrl.sv - pass sequencer for a chain of tiny_dnn_core MAC cores
// Optional build macro: TINY_DNN_CTRL_STALL_EN (exec gated by d_valid).
module tiny_dnn_ctrl #(
  parameter int F_SIZE = 1024,
  parameter int N_CORE = 16,
  localparam int AW = $clog2(F_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] in_len,
  input  logic          use_bias,
  input  logic          d_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          init,
  output logic          exec,
  output logic          bias,
  output logic [AW-1:0] ra,
  output logic          update,
  output logic          outr,
  output logic          out_valid,
  output logic [9:0]    out_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_EXEC, S_BIAS, S_DRAIN, S_SHIFT, S_DONE
  } state_t;

  localparam logic [9:0] K_LAST = 10'(N_CORE - 1);

  state_t        state, state_nx;
  logic [AW-1:0] len_q;
  logic [AW-1:0] cnt;
  logic          bias_q;
  logic [1:0]    drain_cnt;
  logic [9:0]    k;
  logic          exec_en;

`ifdef TINY_DNN_CTRL_STALL_EN
  assign exec_en = d_valid;
`else
  logic unused_d_valid;
  assign unused_d_valid = d_valid;
  assign exec_en = 1'b1;
`endif

  always_comb begin
    state_nx  = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    init      = 1'b0;
    exec      = 1'b0;
    bias      = 1'b0;
    ra        = '0;
    update    = 1'b0;
    outr      = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    case (state)
      S_IDLE: if (start) state_nx = S_INIT;
      S_INIT: begin
        init = 1'b1;
        if (len_q != '0)  state_nx = S_EXEC;
        else if (bias_q)  state_nx = S_BIAS;
        else              state_nx = S_DRAIN;
      end
      S_EXEC: begin
        exec = exec_en;
        ra   = cnt;
        if (exec_en && cnt == len_q - 1'b1)
          state_nx = bias_q ? S_BIAS : S_DRAIN;
      end
      // The core substitutes address F_SIZE-1 for the bias word, so ra stays 0.
      S_BIAS: begin
        bias     = 1'b1;
        state_nx = S_DRAIN;
      end
      S_DRAIN: if (drain_cnt == 2'd2) state_nx = S_SHIFT;
      S_SHIFT: begin
        out_valid = 1'b1;
        out_idx   = k;
        update    = (k == '0);
        outr      = out_ready;
        if (out_ready && k == K_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      bias_q    <= 1'b0;
      cnt       <= '0;
      drain_cnt <= '0;
      k         <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        len_q  <= in_len;
        bias_q <= use_bias;
      end
      if (state == S_EXEC && exec_en)
        cnt <= (state_nx != S_EXEC) ? '0 : cnt + 1'b1;
      if (state == S_DRAIN)
        drain_cnt <= (drain_cnt == 2'd2) ? 2'd0 : drain_cnt + 2'd1;
      // Counters are rewound on exit so the next pass starts from zero.
      if (state == S_SHIFT && out_ready)
        k <= (k == K_LAST) ? 10'd0 : k + 10'd1;
    end
  end

endmodule

// File: tb/tb_tiny_dnn_ctrl.sv
// tb/tb_tiny_dnn_ctrl.sv - randomized check of tiny_dnn_ctrl against a queue-based pass model
module tb_tiny_dnn_ctrl;
  localparam int NC = 2;
  localparam int K_INIT = 1, K_EXEC = 2, K_BIAS = 3, K_QUIET = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, use_bias = 1'b0, d_valid = 1'b0, out_ready = 1'b0;
  logic [9:0] in_len = '0;
  logic       busy, done, init, exec, bias, update, outr, out_valid;
  logic [9:0] ra, out_idx;

  tiny_dnn_ctrl #(.F_SIZE(1024), .N_CORE(NC)) dut (
    .clk(clk), .reset(reset), .start(start), .in_len(in_len), .use_bias(use_bias),
    .d_valid(d_valid), .out_ready(out_ready), .busy(busy), .done(done), .init(init),
    .exec(exec), .bias(bias), .ra(ra), .update(update), .outr(outr),
    .out_valid(out_valid), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: pending control steps of the pass as a queue, then the result walk k, then done.
  int q[$];
  bit m_shift = 0, m_done = 0;
  int m_k = 0;
  int done_seen = 0, exec_seen = 0;
  bit o_valid;

  function automatic bit m_busy();
    return (q.size() > 0) || m_shift || m_done;
  endfunction

  task automatic tick(input bit st, input int len, input bit ub, input bit dv, input bit ordy, input bit rst);
    logic [27:0] exp_v, got_v;
    logic [9:0]  lenv;
    bit e_busy, e_done, e_init, e_exec, e_bias, e_upd, e_outr, e_val, en;
    logic [9:0] e_ra, e_idx;
    int head;
    @(posedge clk); #1;
    lenv = len[9:0];
    start = st; in_len = lenv; use_bias = ub; d_valid = dv; out_ready = ordy; reset = rst;
    {e_busy, e_done, e_init, e_exec, e_bias, e_upd, e_outr, e_val} = '0;
    e_ra = '0; e_idx = '0; head = 0; en = 1'b1;
`ifdef TINY_DNN_CTRL_STALL_EN
    en = dv;
`endif
    if (q.size() > 0) begin
      head = q[0];
      e_busy = 1'b1;
      case (head / 4096)
        K_INIT: e_init = 1'b1;
        K_EXEC: begin e_exec = en; e_ra = 10'(head % 4096); end
        K_BIAS: e_bias = 1'b1;
        default: ;
      endcase
    end else if (m_shift) begin
      e_busy = 1'b1; e_val = 1'b1; e_idx = 10'(m_k);
      e_upd = (m_k == 0); e_outr = ordy;
    end else if (m_done) begin
      e_busy = 1'b1; e_done = 1'b1;
    end
    exp_v = {e_busy, e_done, e_init, e_exec, e_bias, e_upd, e_outr, e_val, e_ra, e_idx};
    @(negedge clk);
    got_v = {busy, done, init, exec, bias, update, outr, out_valid, ra, out_idx};
    check_eq("cycle", {4'd0, got_v}, {4'd0, exp_v});
    if (done) done_seen++;
    if (exec) exec_seen++;
    o_valid = out_valid;
    // advance model across the coming edge
    if (rst) begin
      q.delete(); m_shift = 0; m_done = 0; m_k = 0;
    end else if (q.size() > 0) begin
      if (head / 4096 != K_EXEC || en) void'(q.pop_front());
      if (q.size() == 0) begin m_shift = 1; m_k = 0; end
    end else if (m_shift) begin
      if (ordy) begin
        if (m_k == NC - 1) begin m_shift = 0; m_done = 1; end
        else m_k++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (st) begin
      q.push_back(K_INIT * 4096);
      for (int a = 0; a < int'(lenv); a++) q.push_back(K_EXEC * 4096 + a);
      if (ub) q.push_back(K_BIAS * 4096);
      repeat (3) q.push_back(K_QUIET * 4096);
    end
  endtask

  task automatic run_until_idle(input bit ordy);
    int n = 0;
    while (m_busy() && n < 3000) begin
      tick(0, 0, 0, 1, ordy | ($urandom_range(0, 3) != 0), 0);
      n++;
    end
    check_eq("idle_bound", {31'd0, m_busy()}, 32'd0);
  endtask

  task automatic latency_pass(input int len, input bit ub);
    int lat = 0;
    tick(1, len, ub, 1, 1, 0);
    for (int i = 1; i <= 40; i++) begin
      tick(0, 0, 0, 1, 1, 0);
      if (o_valid) begin lat = i; break; end
    end
    check_eq("latency", lat, 1 + len + ub + 3 + 1);
    run_until_idle(1);
  endtask

  initial begin
    int d0, n;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);

    d0 = done_seen;
    latency_pass(4, 1);
    check_eq("done_once", done_seen - d0, 1);
    latency_pass(0, 0);
    latency_pass(0, 1);
    latency_pass(1, 0);

    // exec gating pattern
    exec_seen = 0;
    tick(1, 3, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    run_until_idle(1);
    check_eq("exec_cnt", exec_seen, 3);

    // consumer backpressure at k=1
    tick(1, 2, 1, 1, 1, 0);
    n = 0;
    while (!(m_shift && m_k == 1) && n < 50) begin tick(0, 0, 0, 1, 1, 0); n++; end
    check_eq("reach_k1", {31'd0, m_shift && m_k == 1}, 32'd1);
    repeat (5) tick(0, 0, 0, 1, 0, 0);
    run_until_idle(1);

    // reset while ra=2 in EXEC
    d0 = done_seen;
    tick(1, 6, 1, 1, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 1, 1);
    tick(0, 0, 0, 1, 1, 0);
    check_eq("rst_no_done", done_seen - d0, 0);
    latency_pass(5, 1);

    // start pulses during SHIFT are ignored
    d0 = done_seen;
    tick(1, 2, 0, 1, 1, 0);
    n = 0;
    while (!m_shift && n < 50) begin tick(0, 0, 0, 1, 1, 0); n++; end
    while (m_shift && n < 100) begin tick(1, 7, 1, 1, $urandom_range(0, 1), 0); n++; end
    run_until_idle(1);
    repeat (3) tick(0, 0, 0, 1, 1, 0);
    check_eq("one_done", done_seen - d0, 1);

    // random traffic
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 12), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    run_until_idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
